// File: rtl/enc_defs.sv
// Shared FSM encodings and small helpers for the 4-to-2 request encoder.
package enc_defs;
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [3:0] v);
    return |(v & (v - 4'd1));
  endfunction
endpackage

// File: rtl/pri_enc4.sv
// Combinational 4-input priority encoder; PRIO_HIGH selects which end wins.
module pri_enc4 #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [3:0] vec,
  output logic [1:0] idx,
  output logic       any
);
  always_comb begin
    idx = 2'b00;
    any = |vec;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 4; i++)
        if (vec[i]) idx = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (vec[i]) idx = 2'(i);
    end
  end
endmodule

// File: rtl/enc4to2_fsm.sv
// Request-latching priority encoder: captures w into pend, grants one index
// at a time with a valid/ack handshake and a sticky multi-hot error flag.
module enc4to2_fsm
  import enc_defs::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       En,
  input  logic [3:0] w,
  input  logic       ack,
  output logic [1:0] y,
  output logic       z,
  output logic       err
);
  state_t     state, state_n;
  logic [3:0] pend, pend_n;
  logic [3:0] capt, cand;
  logic [1:0] y_n, idx;
  logic       z_n, err_n, any;

  assign capt = En ? w : 4'b0000;
  assign cand = pend | capt;

  pri_enc4 #(.PRIO_HIGH(PRIO_HIGH)) u_pri (
    .vec(cand),
    .idx(idx),
    .any(any)
  );

  always_comb begin
    state_n = state;
    pend_n  = pend | capt;
    y_n     = y;
    z_n     = z;
    err_n   = err | (En & multi_hot(w));
    case (state)
      IDLE: begin
        if (any) begin
          y_n     = idx;
          z_n     = 1'b1;
          state_n = SERVE;
        end
      end
      SERVE: begin
        // A same-edge recapture of bit y re-sets it after the clear.
        if (ack) begin
          pend_n  = (pend & ~(4'b0001 << y)) | capt;
          z_n     = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pend  <= 4'b0000;
      y     <= 2'b00;
      z     <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      y     <= y_n;
      z     <= z_n;
      err   <= err_n;
    end
  end
endmodule

// File: tb/tb_enc4to2_fsm.sv
// Directed bench for enc4to2_fsm with both priority orders driven in parallel.
module tb_enc4to2_fsm;
  logic       Clock, Reset, En, ack;
  logic [3:0] w;
  logic [1:0] y_hi, y_lo;
  logic       z_hi, z_lo, err_hi, err_lo;
  int         n_chk  = 0;
  int         n_fail = 0;

  enc4to2_fsm #(.PRIO_HIGH(1'b1)) dut_hi (
    .Clock(Clock), .Reset(Reset), .En(En), .w(w), .ack(ack),
    .y(y_hi), .z(z_hi), .err(err_hi)
  );
  enc4to2_fsm #(.PRIO_HIGH(1'b0)) dut_lo (
    .Clock(Clock), .Reset(Reset), .En(En), .w(w), .ack(ack),
    .y(y_lo), .z(z_lo), .err(err_lo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; w = 4'b0000; ack = 1'b0;
    #1;
    check("rst_y",    {2'b00, y_hi}, 4'b0000);
    check("rst_z",    {3'b000, z_hi}, 4'b0000);
    check("rst_err",  {3'b000, err_hi}, 4'b0000);
    check("rst_pend", dut_hi.pend, 4'b0000);
    step();
    Reset = 1'b0;
    step();
    check("idle_z", {3'b000, z_hi}, 4'b0000);

    // Single request, ack held high
    En = 1'b1; w = 4'b0100; ack = 1'b1;
    step();
    En = 1'b0; w = 4'b0000;
    check("one_z", {3'b000, z_hi}, 4'b0001);
    check("one_y", {2'b00, y_hi}, 4'b0010);
    step();
    check("one_z_drop", {3'b000, z_hi}, 4'b0000);
    check("one_y_hold", {2'b00, y_hi}, 4'b0010);

    // Multi-hot request, both priority orders
    En = 1'b1; w = 4'b1010; ack = 1'b1;
    step();
    En = 1'b0; w = 4'b0000;
    check("mh_err_hi", {3'b000, err_hi}, 4'b0001);
    check("mh_err_lo", {3'b000, err_lo}, 4'b0001);
    check("mh_g1_z_hi", {3'b000, z_hi}, 4'b0001);
    check("mh_g1_y_hi", {2'b00, y_hi}, 4'b0011);
    check("mh_g1_z_lo", {3'b000, z_lo}, 4'b0001);
    check("mh_g1_y_lo", {2'b00, y_lo}, 4'b0001);
    step();
    check("mh_gap_z_hi", {3'b000, z_hi}, 4'b0000);
    check("mh_gap_z_lo", {3'b000, z_lo}, 4'b0000);
    check("mh_gap_pend_hi", dut_hi.pend, 4'b0010);
    check("mh_gap_pend_lo", dut_lo.pend, 4'b1000);
    step();
    check("mh_g2_z_hi", {3'b000, z_hi}, 4'b0001);
    check("mh_g2_y_hi", {2'b00, y_hi}, 4'b0001);
    check("mh_g2_z_lo", {3'b000, z_lo}, 4'b0001);
    check("mh_g2_y_lo", {2'b00, y_lo}, 4'b0011);
    step();
    check("mh_end_z_hi", {3'b000, z_hi}, 4'b0000);
    step();
    check("mh_quiet_z_hi", {3'b000, z_hi}, 4'b0000);
    check("mh_quiet_z_lo", {3'b000, z_lo}, 4'b0000);
    check("mh_quiet_pend", dut_hi.pend, 4'b0000);

    // Hold in SERVE without ack while w toggles under En=0
    En = 1'b1; w = 4'b0001; ack = 1'b0;
    step();
    check("hold_z0", {3'b000, z_hi}, 4'b0001);
    check("hold_y0", {2'b00, y_hi}, 4'b0000);
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = (i % 2 == 0) ? 4'b1111 : 4'b0110;
      step();
      check("hold_z", {3'b000, z_hi}, 4'b0001);
      check("hold_y", {2'b00, y_hi}, 4'b0000);
      check("hold_pend", dut_hi.pend, 4'b0001);
    end

    // Same-edge ack and re-request on the served bit
    En = 1'b1; w = 4'b0001; ack = 1'b1;
    step();
    En = 1'b0; w = 4'b0000; ack = 1'b0;
    check("reack_z", {3'b000, z_hi}, 4'b0000);
    check("reack_pend", dut_hi.pend, 4'b0001);
    step();
    check("reack_z2", {3'b000, z_hi}, 4'b0001);
    check("reack_y2", {2'b00, y_hi}, 4'b0000);
    ack = 1'b1;
    step();
    check("reack_done_z", {3'b000, z_hi}, 4'b0000);
    check("reack_done_pend", dut_hi.pend, 4'b0000);

    // ack while idle is ignored; y keeps its last value
    step();
    check("idle_ack_z", {3'b000, z_hi}, 4'b0000);
    check("idle_ack_y", {2'b00, y_hi}, 4'b0000);

    // Reset mid-SERVE with more requests pending
    En = 1'b1; w = 4'b0100; ack = 1'b0;
    step();
    check("pre_rst_y", {2'b00, y_hi}, 4'b0010);
    check("pre_rst_z", {3'b000, z_hi}, 4'b0001);
    w = 4'b1001;
    step();
    En = 1'b0; w = 4'b0000;
    check("pre_rst_pend", dut_hi.pend, 4'b1101);
    #2 Reset = 1'b1;
    #1;
    check("arst_z",    {3'b000, z_hi}, 4'b0000);
    check("arst_y",    {2'b00, y_hi}, 4'b0000);
    check("arst_err",  {3'b000, err_hi}, 4'b0000);
    check("arst_pend", dut_hi.pend, 4'b0000);
    #1 Reset = 1'b0;

    // Multi-hot with En=0 must not raise err; capture resumes after reset
    En = 1'b0; w = 4'b1111;
    step();
    check("noen_err", {3'b000, err_hi}, 4'b0000);
    check("noen_z",   {3'b000, z_hi}, 4'b0000);
    En = 1'b1; w = 4'b0010;
    step();
    En = 1'b0; w = 4'b0000;
    check("resume_z",   {3'b000, z_hi}, 4'b0001);
    check("resume_y",   {2'b00, y_hi}, 4'b0001);
    check("resume_err", {3'b000, err_hi}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/enc4to2_fsm.md
ENC4TO2_FSM -- requirements
Module: enc4to2_fsm

Interface
REQ-001 SHALL have parameter PRIO_HIGH, default 1, meaning 1 = w[3] highest priority, 0 = w[0] highest priority.
REQ-002 SHALL have port Clock  input  1  single clock, rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port En  input  1  enable for capturing new requests.
REQ-005 SHALL have port w  input  4  request lines; one-hot expected, any pattern accepted.
REQ-006 SHALL have port ack  input  1  consumer accepts the presented code.
REQ-007 SHALL have port y  output  2  registered binary index of the served request.
REQ-008 SHALL have port z  output  1  registered valid; y is meaningful only when z=1.
REQ-009 SHALL have port err  output  1  sticky flag: multi-hot w seen while En=1.

Function
REQ-010 SHALL hold a 4-bit pending register pend; at each edge with En=1, pend |= w; with En=0, w is ignored.
REQ-011 SHALL implement a two-state FSM, IDLE and SERVE; the reset state is IDLE.
REQ-012 SHALL, in IDLE, form cand = pend | (En ? w : 4'b0000).
REQ-013 SHALL, in IDLE with cand nonzero, load y = priority index of cand per PRIO_HIGH, set z=1, and go to SERVE at the same edge (latency: one edge from w to z).
REQ-014 SHALL, in IDLE with cand = 0, keep z=0 and y unchanged.
REQ-015 SHALL, in SERVE, hold y and z stable until ack=1 is sampled.
REQ-016 SHALL, in SERVE with ack=1, clear pend[y], drive z=0, and return to IDLE; this forces one idle cycle between grants.
REQ-017 SHALL let a new request on bit y win when it arrives with En=1 in the same edge as the ack: pend[y] remains 1.
REQ-018 SHALL ignore ack while z=0.
REQ-019 SHALL keep serving (SERVE, ack) while En=0; only capture is gated by En.
REQ-020 SHALL set err at any edge where En=1 and w has two or more bits set; err is cleared only by Reset.
REQ-021 SHALL leave requests from a multi-hot w pending and serve them one at a time in priority order.
REQ-022 SHALL leave y unchanged when the request is dropped.

Reset
REQ-023 SHALL, on Reset=1, asynchronously force: state=IDLE, pend=4'b0000, y=2'b00, z=0, err=0.
REQ-024 SHALL, on Reset asserted mid-SERVE, abort the grant immediately and drop all pending requests.
REQ-025 SHALL resume normal capture at the first rising edge after Reset deasserts.

Structure
REQ-026 SHALL place the state encodings (IDLE=1'b0, SERVE=1'b1) in a shared constants package/include, enc_defs.
REQ-027 SHALL use one combinational sub-module pri_enc4 (inputs: 4-bit vector and PRIO_HIGH; outputs: 2-bit index and any-set flag); all other logic is local.

Verification
REQ-028 SHALL cover this scenario: Reset pulse mid-SERVE (y=2'b10, z=1) -> z=0, y=2'b00, err=0, and pend empty immediately, without waiting for a clock edge.
REQ-029 SHALL cover this scenario: En=1, w=4'b0100 for one cycle, ack held high -> z=1, y=2'b10 after one edge; z=0 after the next edge.
REQ-030 SHALL cover this scenario: PRIO_HIGH=1, En=1, w=4'b1010 for one cycle, ack=1 -> err=1; grants y=2'b11, then idle cycle, then y=2'b01; then z stays 0.
REQ-031 SHALL cover this scenario: PRIO_HIGH=0, same stimulus -> grants y=2'b01 then y=2'b11.
REQ-032 SHALL cover this scenario: in SERVE with y=2'b00, ack=0 for 5 cycles, w toggling with En=0 -> y and z stable; pend unchanged.
REQ-033 SHALL cover this scenario: ack=1 and En=1, w=4'b0001 at the same edge while serving y=2'b00 -> z=0 for one cycle, then z=1, y=2'b00 again.
